// File: rtl/vx_fpu_lane_sequencer.sv
// vx_fpu_lane_sequencer: time-multiplexes lane operands onto fixed-latency PEs and reassembles results
module vx_fpu_lane_sequencer #(
    parameter int NUM_LANES      = 4,
    parameter int NUM_PES        = 1,
    parameter int LATENCY        = 4,
    parameter int DATA_IN_WIDTH  = 36,
    parameter int DATA_OUT_WIDTH = 37,
    parameter int TAG_WIDTH      = 1
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                valid_in,
    output logic                                ready_in,
    input  logic [NUM_LANES*DATA_IN_WIDTH-1:0]  data_in,
    input  logic [TAG_WIDTH-1:0]                tag_in,
    output logic                                pe_enable,
    output logic [NUM_PES*DATA_IN_WIDTH-1:0]    pe_data_out,
    input  logic [NUM_PES*DATA_OUT_WIDTH-1:0]   pe_data_in,
    output logic                                valid_out,
    output logic [NUM_LANES*DATA_OUT_WIDTH-1:0] data_out,
    output logic [TAG_WIDTH-1:0]                tag_out,
    input  logic                                ready_out
);
    localparam int BATCHES = (NUM_LANES + NUM_PES - 1) / NUM_PES;
    localparam int BW      = BATCHES > 1 ? $clog2(BATCHES) : 1;
    localparam int IW      = NUM_PES * DATA_IN_WIDTH;
    localparam int OW      = NUM_PES * DATA_OUT_WIDTH;
    localparam logic [BW-1:0] LAST = BW'(BATCHES - 1);

    logic [BATCHES*IW-1:0]               lanes_in;
    logic [BW-1:0]                       batch_idx_q, batch_idx_d;
    logic [LATENCY-1:0]                  trk_valid_q, trk_valid_d;
    logic [LATENCY-1:0]                  trk_last_q, trk_last_d;
    logic [BW-1:0]                       trk_idx_q [LATENCY];
    logic [BW-1:0]                       trk_idx_d [LATENCY];
    logic [TAG_WIDTH-1:0]                trk_tag_q [LATENCY];
    logic [TAG_WIDTH-1:0]                trk_tag_d [LATENCY];
    logic [BATCHES*OW-1:0]               buf_q, buf_d;
    logic                                valid_out_q, valid_out_d;
    logic [NUM_LANES*DATA_OUT_WIDTH-1:0] data_out_q, data_out_d;
    logic [TAG_WIDTH-1:0]                tag_out_q, tag_out_d;
    logic                                issue, is_last, exit_any, exit_last;

    always_comb begin
        pe_enable   = !(valid_out_q && !ready_out);
        issue       = valid_in && pe_enable;
        is_last     = batch_idx_q == LAST;
        ready_in    = issue && is_last;
        // lanes past NUM_LANES in the final batch read as zero padding
        lanes_in    = (BATCHES*IW)'(data_in);
        pe_data_out = valid_in ? lanes_in[batch_idx_q*IW +: IW] : '0;
        batch_idx_d = issue ? (is_last ? '0 : batch_idx_q + 1'b1) : batch_idx_q;
        trk_valid_d = trk_valid_q;
        trk_last_d  = trk_last_q;
        trk_idx_d   = trk_idx_q;
        trk_tag_d   = trk_tag_q;
        if (pe_enable) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                trk_valid_d[i] = trk_valid_q[i-1];
                trk_last_d[i]  = trk_last_q[i-1];
                trk_idx_d[i]   = trk_idx_q[i-1];
                trk_tag_d[i]   = trk_tag_q[i-1];
            end
            trk_valid_d[0] = valid_in;
            trk_last_d[0]  = is_last;
            trk_idx_d[0]   = batch_idx_q;
            trk_tag_d[0]   = is_last ? tag_in : '0;
        end
        // the tracking pipe and the PEs advance together, so the exiting entry matches pe_data_in
        exit_any  = pe_enable && trk_valid_q[LATENCY-1];
        exit_last = exit_any && trk_last_q[LATENCY-1];
        buf_d     = buf_q;
        if (exit_any)
            buf_d[trk_idx_q[LATENCY-1]*OW +: OW] = pe_data_in;
        valid_out_d = exit_last || (valid_out_q && !ready_out);
        data_out_d  = exit_last ? buf_d[NUM_LANES*DATA_OUT_WIDTH-1:0] : data_out_q;
        tag_out_d   = exit_last ? trk_tag_q[LATENCY-1] : tag_out_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            batch_idx_q <= '0;
            trk_valid_q <= '0;
            trk_last_q  <= '0;
            trk_idx_q   <= '{default: '0};
            trk_tag_q   <= '{default: '0};
            buf_q       <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            tag_out_q   <= '0;
        end else begin
            batch_idx_q <= batch_idx_d;
            trk_valid_q <= trk_valid_d;
            trk_last_q  <= trk_last_d;
            trk_idx_q   <= trk_idx_d;
            trk_tag_q   <= trk_tag_d;
            buf_q       <= buf_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            tag_out_q   <= tag_out_d;
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign tag_out   = tag_out_q;
endmodule

// File: tb/tb_vx_fpu_lane_sequencer.sv
// tb_vx_fpu_lane_sequencer: three configurations, each with a +1 PE pipe model, checked against a request-level scoreboard
module tb_vx_fpu_lane_sequencer;
    logic clk;
    int   n_chk, n_pass;

    logic         a_rstn, a_vin, a_rdy, a_tin, a_en, a_vout, a_tout, a_rout;
    logic [143:0] a_din;
    logic [35:0]  a_pe_out;
    logic [36:0]  a_pe_in;
    logic [147:0] a_dout;
    logic [36:0]  a_pp [4];

    logic         bc_rstn;
    logic         b_vin, b_rdy, b_tin, b_en, b_vout, b_tout, b_rout;
    logic [107:0] b_din;
    logic [71:0]  b_pe_out;
    logic [73:0]  b_pe_in;
    logic [110:0] b_dout;
    logic [73:0]  b_pp [2];

    logic         c_vin, c_rdy, c_tin, c_en, c_vout, c_tout, c_rout;
    logic [143:0] c_din;
    logic [143:0] c_pe_out;
    logic [147:0] c_pe_in;
    logic [147:0] c_dout;
    logic [147:0] c_pp [4];

    vx_fpu_lane_sequencer #(.NUM_LANES(4), .NUM_PES(1), .LATENCY(4)) dut_a (
        .clk(clk), .resetn(a_rstn), .valid_in(a_vin), .ready_in(a_rdy), .data_in(a_din), .tag_in(a_tin),
        .pe_enable(a_en), .pe_data_out(a_pe_out), .pe_data_in(a_pe_in), .valid_out(a_vout),
        .data_out(a_dout), .tag_out(a_tout), .ready_out(a_rout));

    vx_fpu_lane_sequencer #(.NUM_LANES(3), .NUM_PES(2), .LATENCY(2)) dut_b (
        .clk(clk), .resetn(bc_rstn), .valid_in(b_vin), .ready_in(b_rdy), .data_in(b_din), .tag_in(b_tin),
        .pe_enable(b_en), .pe_data_out(b_pe_out), .pe_data_in(b_pe_in), .valid_out(b_vout),
        .data_out(b_dout), .tag_out(b_tout), .ready_out(b_rout));

    vx_fpu_lane_sequencer #(.NUM_LANES(4), .NUM_PES(4), .LATENCY(4)) dut_c (
        .clk(clk), .resetn(bc_rstn), .valid_in(c_vin), .ready_in(c_rdy), .data_in(c_din), .tag_in(c_tin),
        .pe_enable(c_en), .pe_data_out(c_pe_out), .pe_data_in(c_pe_in), .valid_out(c_vout),
        .data_out(c_dout), .tag_out(c_tout), .ready_out(c_rout));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [147:0] inc4(input logic [143:0] x);
        logic [147:0] r;
        for (int k = 0; k < 4; k++) r[k*37 +: 37] = {1'b0, x[k*36 +: 36]} + 37'd1;
        return r;
    endfunction

    function automatic logic [143:0] rnd144();
        logic [143:0] r;
        for (int k = 0; k < 4; k++) r[k*36 +: 36] = 36'({$urandom(), $urandom()});
        return r;
    endfunction

    // PE models: LATENCY-stage pipes producing operand+1 per lane, advanced only on pe_enable
    always @(posedge clk) if (a_en) begin
        a_pp[0] <= 37'(inc4(144'(a_pe_out)));
        for (int i = 1; i < 4; i++) a_pp[i] <= a_pp[i-1];
    end
    assign a_pe_in = a_pp[3];

    always @(posedge clk) if (b_en) begin
        b_pp[0] <= 74'(inc4(144'(b_pe_out)));
        b_pp[1] <= b_pp[0];
    end
    assign b_pe_in = b_pp[1];

    always @(posedge clk) if (c_en) begin
        c_pp[0] <= inc4(c_pe_out);
        for (int i = 1; i < 4; i++) c_pp[i] <= c_pp[i-1];
    end
    assign c_pe_in = c_pp[3];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic chkw(input string name, input logic [147:0] act, input logic [147:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // request-level reference for dut_a: a request is accepted on its 4th enabled valid cycle
    typedef struct { logic [147:0] d; logic t; } rsp_t;
    rsp_t         exp_q [$];
    int           a_nb, a_got;
    logic         a_prev_stall;
    logic [147:0] a_prev_d;
    logic         a_prev_t;

    task automatic mon_a();
        logic stall;
        rsp_t r;
        if (!a_rstn) begin
            exp_q.delete();
            a_nb = 0;
            a_prev_stall = 1'b0;
            return;
        end
        stall = a_vout && !a_rout;
        chk1("a_pe_enable", a_en, !stall);
        chk1("a_ready_in", a_rdy, a_vin && !stall && a_nb == 3);
        chkw("a_pe_data_out", 148'(a_pe_out), a_vin ? 148'(a_din[a_nb*36 +: 36]) : 148'(0));
        if (a_prev_stall) begin
            chk1("a_hold_valid", a_vout, 1'b1);
            chkw("a_hold_data", a_dout, a_prev_d);
            chk1("a_hold_tag", a_tout, a_prev_t);
        end
        if (a_vout && a_rout) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL a_rsp_extra: got %0h with nothing pending at %0t", a_dout, $time);
            end else begin
                r = exp_q.pop_front();
                chkw("a_rsp_data", a_dout, r.d);
                chk1("a_rsp_tag", a_tout, r.t);
                a_got++;
            end
        end
        if (a_vin && !stall) begin
            if (a_nb == 3) begin
                exp_q.push_back('{d: inc4(a_din), t: a_tin});
                a_nb = 0;
            end else a_nb++;
        end
        a_prev_stall = stall;
        a_prev_d = a_dout;
        a_prev_t = a_tout;
    endtask

    task automatic sample();
        @(negedge clk);
        mon_a();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // mode 0: continuous traffic, exact timing; mode 1: 10-cycle output stall; mode 2: random gaps and stalls
    task automatic run_a(input int n, input int mode, input int lim);
        int sent, k, target;
        logic [143:0] d;
        logic t;
        sent = 0;
        k = 0;
        target = a_got + n;
        d = rnd144();
        t = 1'($urandom_range(0, 1));
        while ((sent < n || a_got < target) && k < lim) begin
            a_vin = sent < n && (mode != 2 || $urandom_range(0, 3) != 0);
            a_din = d;
            a_tin = t;
            a_rout = mode == 2 ? $urandom_range(0, 2) != 0 : mode == 1 ? !(k >= 8 && k < 18) : 1'b1;
            sample();
            if (mode == 0) begin
                chk1("a_bb_enable", a_en, 1'b1);
                chk1("a_bb_ready_in", a_rdy, k % 4 == 3 && k < 4 * n);
                chk1("a_bb_valid_out", a_vout, k >= 8 && (k - 8) % 4 == 0 && (k - 8) / 4 < n);
            end
            if (mode == 1 && k >= 8 && k < 18) begin
                chk1("a_stall_enable", a_en, 1'b0);
                chk1("a_stall_ready_in", a_rdy, 1'b0);
            end
            if (a_vin && a_rdy) begin
                sent++;
                d = rnd144();
                t = 1'($urandom_range(0, 1));
            end
            adv();
            k++;
        end
        chk1("a_run_done", k < lim, 1'b1);
        chk1("a_queue_empty", exp_q.size() == 0, 1'b1);
    endtask

    typedef struct { logic vin; logic rout; logic exp_rdy; logic exp_vout; } vec_t;
    vec_t tbl [10];
    logic [143:0] c_req [4];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_pass = 0; a_nb = 0; a_got = 0; a_prev_stall = 1'b0; a_prev_d = '0; a_prev_t = 1'b0;
        a_rstn = 1'b0; a_vin = 1'b0; a_din = '0; a_tin = 1'b0; a_rout = 1'b1;
        bc_rstn = 1'b0; b_vin = 1'b0; b_din = '0; b_tin = 1'b0; b_rout = 1'b1;
        c_vin = 1'b0; c_din = '0; c_tin = 1'b0; c_rout = 1'b1;
        repeat (3) begin sample(); adv(); end
        a_rstn = 1'b1; bc_rstn = 1'b1;
        sample();
        chk1("a_rst_valid", a_vout, 1'b0); chkw("a_rst_data", a_dout, '0); chk1("a_rst_tag", a_tout, 1'b0);
        chk1("b_rst_valid", b_vout, 1'b0); chkw("b_rst_data", 148'(b_dout), '0);
        chk1("c_rst_valid", c_vout, 1'b0); chkw("c_rst_data", c_dout, '0); chk1("c_rst_tag", c_tout, 1'b0);
        adv();

        // single request, lanes {4,3,2,1}, tag 1
        tbl[0] = '{1, 1, 0, 0}; tbl[1] = '{1, 1, 0, 0}; tbl[2] = '{1, 1, 0, 0}; tbl[3] = '{1, 1, 1, 0};
        tbl[4] = '{0, 1, 0, 0}; tbl[5] = '{0, 1, 0, 0}; tbl[6] = '{0, 1, 0, 0}; tbl[7] = '{0, 1, 0, 0};
        tbl[8] = '{0, 1, 0, 1}; tbl[9] = '{0, 1, 0, 0};
        a_din = {36'd4, 36'd3, 36'd2, 36'd1};
        a_tin = 1'b1;
        for (int k = 0; k < 10; k++) begin
            a_vin = tbl[k].vin;
            a_rout = tbl[k].rout;
            sample();
            chk1("t1_ready_in", a_rdy, tbl[k].exp_rdy);
            chk1("t1_valid_out", a_vout, tbl[k].exp_vout);
            chk1("t1_enable", a_en, 1'b1);
            if (tbl[k].exp_vout) begin
                chkw("t1_data_out", a_dout, {37'd5, 37'd4, 37'd3, 37'd2});
                chk1("t1_tag_out", a_tout, 1'b1);
            end
            adv();
        end

        run_a(3, 0, 60);
        run_a(3, 1, 80);

        // reset after the first batch of a request is issued
        a_din = rnd144(); a_tin = 1'b1; a_rout = 1'b1; a_vin = 1'b1;
        sample(); adv();
        a_vin = 1'b0; a_rstn = 1'b0;
        sample(); adv();
        a_rstn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            sample();
            chk1("t5_no_response", a_vout, 1'b0);
            adv();
        end
        run_a(1, 0, 40);

        // three lanes on two PEs: lane 1 of batch 1 is padding
        b_din = {36'd9, 36'd8, 36'd7}; b_tin = 1'b1; b_rout = 1'b1;
        for (int k = 0; k < 8; k++) begin
            b_vin = k < 2;
            sample();
            if (k == 0) begin
                chkw("b_pe_batch0", 148'(b_pe_out), 148'({36'd8, 36'd7}));
                chk1("b_ready_b0", b_rdy, 1'b0);
            end
            if (k == 1) begin
                chkw("b_pe_batch1", 148'(b_pe_out), 148'({36'd0, 36'd9}));
                chk1("b_ready_b1", b_rdy, 1'b1);
            end
            if (k == 2) chkw("b_pe_idle", 148'(b_pe_out), '0);
            chk1("b_valid_out", b_vout, k == 4);
            if (k == 4) begin
                chkw("b_data_out", 148'(b_dout), 148'({37'd10, 37'd9, 37'd8}));
                chk1("b_tag_out", b_tout, 1'b1);
            end
            adv();
        end

        // one PE per lane: a request accepted every cycle
        for (int j = 0; j < 4; j++) c_req[j] = rnd144();
        c_rout = 1'b1;
        for (int k = 0; k < 11; k++) begin
            c_vin = k < 4;
            c_din = k < 4 ? c_req[k] : '0;
            c_tin = k[0];
            sample();
            chk1("c_ready_in", c_rdy, k < 4);
            chk1("c_valid_out", c_vout, k >= 5 && k < 9);
            if (k >= 5 && k < 9) begin
                chkw("c_data_out", c_dout, inc4(c_req[k-5]));
                chk1("c_tag_out", c_tout, (k - 5) % 2 == 1);
            end
            adv();
        end

        run_a(30, 2, 4000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
